// File: rtl/marie_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : marie_pkg
//  Purpose  : Shared constants, opcode encoding and fetch FSM state type for
//             the MARIE fetch/decode stage.
//  Ports    : (package - none)
//  Revision : 1.0  initial release
// ============================================================================
package marie_pkg;

  localparam int ADDR_W   = 12;
  localparam int DATA_W   = 16;
  localparam int OPCODE_W = 4;

  // Instruction opcodes carried in IR[DATA_W-1 -: OPCODE_W]
  typedef enum logic [OPCODE_W-1:0] {
    OP_LOAD     = 4'h1,
    OP_STORE    = 4'h2,
    OP_ADD      = 4'h3,
    OP_SUBT     = 4'h4,
    OP_INPUT    = 4'h5,
    OP_OUTPUT   = 4'h6,
    OP_HALT     = 4'h7,
    OP_SKIPCOND = 4'h8,
    OP_JUMP     = 4'h9
  } opcode_t;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_MEM_WAIT  = 3'd2,
    ST_ISSUE     = 3'd3,
    ST_EXEC_WAIT = 3'd4,
    ST_HALT      = 3'd5
  } fetch_state_t;

  function automatic logic is_halt(input logic [OPCODE_W-1:0] op);
    return op == OP_HALT;
  endfunction

endpackage : marie_pkg
`default_nettype wire

// File: rtl/marie_pc_reg.sv
`default_nettype none
// ============================================================================
//  Module   : marie_pc_reg
//  Purpose  : Program counter register. Load has priority over increment;
//             the fetch increment and the skip increment both add one,
//             wrapping modulo 2^ADDR_W.
//  Ports    : clk, rst        clock / async active-high reset (PC=RESET_PC)
//             inc_en          post-fetch increment
//             skip_en         skip increment requested by execute
//             load_en         redirect PC to load_val
//             load_val        jump target
//             pc              current PC value
//  Revision : 1.0  initial release
// ============================================================================
module marie_pc_reg #(
  parameter int                 ADDR_W   = 12,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc_en,
  input  logic              skip_en,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_val,
  output logic [ADDR_W-1:0] pc
);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (load_en) begin
      pc_d = load_val;
    end else if (inc_en || skip_en) begin
      pc_d = pc_q + ADDR_W'(1);   // natural wrap 0xFFF -> 0x000
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule : marie_pc_reg
`default_nettype wire

// File: rtl/marie_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : marie_fetch_unit
//  Purpose  : MARIE instruction fetch/decode stage. Reads M[PC], latches it
//             into IR, presents opcode/operand to execute over a valid/ready
//             handshake, waits for exec_done and applies jump/skip.
//  Ports    : clk, rst                    clock / async active-high reset
//             start                       begin fetching (IDLE only)
//             mem_rd_en, mem_addr         memory read strobe / address
//             mem_rdata                   read data, one cycle after strobe
//             instr_valid, exec_ready     issue handshake
//             opcode, operand             IR fields
//             pc_out                      current PC
//             exec_done, pc_load,
//             pc_load_val, skip           completion and PC redirect
//             halted                      Halt instruction fetched
//  Revision : 1.0  initial release
// ============================================================================
module marie_fetch_unit
  import marie_pkg::*;
#(
  parameter int ADDR_W   = marie_pkg::ADDR_W,
  parameter int DATA_W   = marie_pkg::DATA_W,
  parameter int OPCODE_W = marie_pkg::OPCODE_W,
  parameter int RESET_PC = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                mem_rd_en,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                instr_valid,
  input  logic                exec_ready,
  output logic [OPCODE_W-1:0] opcode,
  output logic [ADDR_W-1:0]   operand,
  output logic [ADDR_W-1:0]   pc_out,
  input  logic                exec_done,
  input  logic                pc_load,
  input  logic [ADDR_W-1:0]   pc_load_val,
  input  logic                skip,
  output logic                halted
);

  fetch_state_t      state_q, state_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;

  logic              pc_inc;
  logic              pc_skip;
  logic              pc_ld;
  logic [ADDR_W-1:0] pc;

  marie_pc_reg #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (ADDR_W'(RESET_PC))
  ) u_pc_reg (
    .clk      (clk),
    .rst      (rst),
    .inc_en   (pc_inc),
    .skip_en  (pc_skip),
    .load_en  (pc_ld),
    .load_val (pc_load_val),
    .pc       (pc)
  );

  always_comb begin
    state_d    = state_q;
    ir_d       = ir_q;
    mem_addr_d = mem_addr_q;
    pc_inc     = 1'b0;
    pc_skip    = 1'b0;
    pc_ld      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        // Remember the address so mem_addr holds it once the strobe drops
        mem_addr_d = pc;
        state_d    = ST_MEM_WAIT;
      end
      ST_MEM_WAIT: begin
        ir_d   = mem_rdata;
        pc_inc = 1'b1;
        if (is_halt(mem_rdata[DATA_W-1 -: OPCODE_W])) begin
          state_d = ST_HALT;
        end else begin
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // exec_done here is deliberately ignored, even alongside exec_ready
        if (exec_ready) state_d = ST_EXEC_WAIT;
      end
      ST_EXEC_WAIT: begin
        if (exec_done) begin
          pc_ld   = pc_load;
          pc_skip = skip & ~pc_load;   // jump beats skip
          state_d = ST_FETCH;
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ir_q       <= '0;
      mem_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      ir_q       <= ir_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  // Outputs decode from state so an asynchronous reset clears them at once
  assign mem_rd_en   = (state_q == ST_FETCH);
  assign mem_addr    = mem_rd_en ? pc : mem_addr_q;
  assign instr_valid = (state_q == ST_ISSUE);
  assign halted      = (state_q == ST_HALT);
  assign opcode      = ir_q[DATA_W-1 -: OPCODE_W];
  assign operand     = ir_q[ADDR_W-1:0];
  assign pc_out      = pc;

endmodule : marie_fetch_unit
`default_nettype wire

// File: tb/tb_marie_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_marie_fetch_unit
//  Purpose  : Self-checking bench for marie_fetch_unit. A memory array and a
//             program-level PC model predict every fetch address, decoded
//             field and PC value; handshake timing is randomized.
//  Revision : 1.0  initial release
// ============================================================================
module tb_marie_fetch_unit;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 16;
  localparam int OPC_W  = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic              instr_valid;
  logic              exec_ready = 1'b0;
  logic [OPC_W-1:0]  opcode;
  logic [ADDR_W-1:0] operand;
  logic [ADDR_W-1:0] pc_out;
  logic              exec_done = 1'b0;
  logic              pc_load = 1'b0;
  logic [ADDR_W-1:0] pc_load_val = '0;
  logic              skip = 1'b0;
  logic              halted;

  marie_fetch_unit #(.RESET_PC(0)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .mem_rd_en   (mem_rd_en),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .instr_valid (instr_valid),
    .exec_ready  (exec_ready),
    .opcode      (opcode),
    .operand     (operand),
    .pc_out      (pc_out),
    .exec_done   (exec_done),
    .pc_load     (pc_load),
    .pc_load_val (pc_load_val),
    .skip        (skip),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  // Unified memory: data returned the cycle after the read strobe
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= mem[mem_addr];
  end

  int n_cmp = 0;
  int n_err = 0;

  // Reference state: program counter of the next instruction, plus the
  // instruction word the DUT is expected to be holding.
  int unsigned       model_pc;
  logic [DATA_W-1:0] model_ir;
  bit                model_halt;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_rd_en"},  32'(mem_rd_en),   32'd0);
    check_eq({tag, "_addr"},   32'(mem_addr),    32'd0);
    check_eq({tag, "_valid"},  32'(instr_valid), 32'd0);
    check_eq({tag, "_halted"}, 32'(halted),      32'd0);
    check_eq({tag, "_pc"},     32'(pc_out),      32'd0);
    check_eq({tag, "_opcode"}, 32'(opcode),      32'd0);
    check_eq({tag, "_operand"},32'(operand),     32'd0);
  endtask

  function automatic logic [DATA_W-1:0] rand_non_halt();
    logic [DATA_W-1:0] w;
    w = DATA_W'($urandom);
    if (w[15:12] == 4'h7) w[15:12] = 4'h3;
    return w;
  endfunction

  // Called at the negedge where a fetch strobe is due. Checks the fetch,
  // the bubble cycle and the issued instruction.
  task automatic issue_phase(input string tag);
    check_eq({tag, "_rd_en"}, 32'(mem_rd_en), 32'd1);
    check_eq({tag, "_addr"},  32'(mem_addr),  32'(model_pc));
    model_ir   = mem[model_pc];
    model_pc   = (model_pc + 1) % (1 << ADDR_W);
    model_halt = (model_ir[15:12] == 4'h7);
    @(negedge clk);
    check_eq({tag, "_bubble_valid"}, 32'(instr_valid), 32'd0);
    check_eq({tag, "_bubble_rd"},    32'(mem_rd_en),   32'd0);
    @(negedge clk);
    if (model_halt) begin
      check_eq({tag, "_halted"},   32'(halted),      32'd1);
      check_eq({tag, "_hvalid"},   32'(instr_valid), 32'd0);
    end else begin
      check_eq({tag, "_valid"},    32'(instr_valid), 32'd1);
      check_eq({tag, "_opcode"},   32'(opcode),      32'(model_ir[15:12]));
      check_eq({tag, "_operand"},  32'(operand),     32'(model_ir[11:0]));
    end
    check_eq({tag, "_pc"}, 32'(pc_out), 32'(model_pc));
  endtask

  // Starting at the negedge where instr_valid is first high: stall, accept,
  // wait, then complete with the given redirect. Ends at the next fetch.
  task automatic exec_phase(input string tag, input int rdly, input int ddly,
                            input bit ld, input logic [ADDR_W-1:0] ldv,
                            input bit sk);
    for (int i = 0; i < rdly; i++) begin
      exec_ready  = 1'b0;
      exec_done   = 1'($urandom);          // stray completions must be ignored
      pc_load     = 1'b1;
      pc_load_val = ADDR_W'($urandom);
      skip        = 1'($urandom);
      start       = 1'($urandom);
      @(negedge clk);
      check_eq({tag, "_stall_valid"},   32'(instr_valid), 32'd1);
      check_eq({tag, "_stall_opcode"},  32'(opcode),      32'(model_ir[15:12]));
      check_eq({tag, "_stall_operand"}, 32'(operand),     32'(model_ir[11:0]));
    end
    exec_ready  = 1'b1;
    exec_done   = 1'($urandom);
    pc_load     = 1'($urandom);
    pc_load_val = ADDR_W'($urandom);
    skip        = 1'($urandom);
    start       = 1'b0;
    @(negedge clk);
    exec_ready = 1'b0;
    exec_done  = 1'b0;
    pc_load    = 1'b0;
    skip       = 1'b0;
    check_eq({tag, "_accept_valid"}, 32'(instr_valid), 32'd0);
    for (int i = 0; i < ddly; i++) begin
      start = 1'($urandom);
      @(negedge clk);
      check_eq({tag, "_wait_rd"}, 32'(mem_rd_en), 32'd0);
    end
    start       = 1'b0;
    exec_done   = 1'b1;
    pc_load     = ld;
    pc_load_val = ldv;
    skip        = sk;
    @(negedge clk);
    exec_done = 1'b0;
    pc_load   = 1'b0;
    skip      = 1'b0;
    if (ld)      model_pc = int'(ldv);
    else if (sk) model_pc = (model_pc + 1) % (1 << ADDR_W);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    for (int a = 0; a < (1 << ADDR_W); a++) mem[a] = rand_non_halt();
    mem[0]     = 16'h1005;
    mem[1]     = 16'h9010;
    model_pc   = 0;
    model_ir   = '0;
    model_halt = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);
    check_eq("idle_rd_en", 32'(mem_rd_en), 32'd0);

    // Load at address 0, with a 5-cycle stall on exec_ready
    do_start();
    issue_phase("t1");
    exec_phase("t2", 5, 2, 1'b0, '0, 1'b0);

    // Jump at address 1 with skip also set: jump wins
    issue_phase("t3");
    exec_phase("t3", 0, 0, 1'b1, 12'h010, 1'b1);

    // Randomized program flow
    for (int n = 0; n < 40; n++) begin
      bit ld, sk;
      ld = ($urandom_range(0, 3) == 0);
      sk = 1'($urandom);
      issue_phase("rnd");
      exec_phase("rnd", $urandom_range(0, 3), $urandom_range(0, 3),
                 ld, ADDR_W'($urandom), sk);
    end

    // Wrap: jump to 0xFFE, fetch makes PC 0xFFF, skip wraps it to 0x000
    issue_phase("w0");
    exec_phase("w0", 0, 0, 1'b1, 12'hFFE, 1'b0);
    issue_phase("w1");
    check_eq("wrap_pc_fff", 32'(pc_out), 32'hFFF);
    exec_phase("w1", 1, 1, 1'b0, '0, 1'b1);
    check_eq("wrap_pc_zero", 32'(pc_out), 32'h000);
    issue_phase("w2");
    exec_phase("w2", 0, 0, 1'b0, '0, 1'b0);

    // Reset while in MEM_WAIT
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_memwait");
    @(negedge clk);
    rst = 1'b0;
    model_pc = 0;
    @(negedge clk);
    do_start();
    issue_phase("rs1");
    // Reset while in ISSUE
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_issue");
    @(negedge clk);
    rst = 1'b0;
    model_pc = 0;
    @(negedge clk);
    do_start();
    issue_phase("rs2");
    exec_phase("rs2", 0, 0, 1'b1, 12'h123, 1'b0);

    // Halt
    mem[12'h200] = 16'h7000;
    issue_phase("pre_halt");
    exec_phase("pre_halt", 0, 0, 1'b1, 12'h200, 1'b0);
    issue_phase("halt");
    for (int i = 0; i < 6; i++) begin
      start = 1'($urandom);
      @(negedge clk);
      check_eq("halt_rd_en",  32'(mem_rd_en),   32'd0);
      check_eq("halt_valid",  32'(instr_valid), 32'd0);
      check_eq("halt_halted", 32'(halted),      32'd1);
    end
    start = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_marie_fetch_unit
`default_nettype wire
